alu_op_sequencer: RTL and testbench

- Sequences one arithmetic job at a time for the calculator.
- Takes two unsigned operands and a 4-bit key-code opcode from the keypad FSM, and returns a registered result with status flags.
- Add/sub complete in one cycle; multiply (shift-add) and divide (restoring) are iterative, one bit per cycle.
- Sits between the keypad/display FSM and the display path. It replaces combinational multiply/divide, so timing holds at the board clock.

---
 rtl/calc_pkg.sv | 28 ++
 rtl/alu_op_sequencer_if.sv | 41 ++++
 rtl/alu_iter_core.sv | 65 ++++++
 rtl/alu_op_sequencer.sv | 178 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: ALU opcodes (which are also keypad key codes),
// sequencer state encoding and the digit-key code list.
package calc_pkg;

  // Operator key codes; the ALU sequencer consumes these directly as opcodes.
  localparam logic [3:0] OP_PLUS  = 4'b0011;
  localparam logic [3:0] OP_MINUS = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b0111;
  localparam logic [3:0] OP_DIV   = 4'b1111;

  // Digit key codes 0..9, chosen so that none collides with an operator code.
  localparam logic [9:0][3:0] KEY_DIGITS = {
    4'b1100, 4'b1010, 4'b1001, 4'b1000, 4'b0110,
    4'b0101, 4'b0100, 4'b0010, 4'b0001, 4'b0000
  };

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  // True for codes that need the iterative datapath (divide only when b is nonzero).
  function automatic logic is_iter_op(input logic [3:0] op, input logic b_is_zero);
    return (op == OP_MULT) || ((op == OP_DIV) && !b_is_zero);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Job request / result bus between the keypad FSM (master) and the ALU
// sequencer (slave). The rem signal exists only with ALU_SEQ_REMAINDER_EN.
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] num_a;
  logic [WIDTH-1:0] num_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             err;

`ifdef ALU_SEQ_REMAINDER_EN
  logic [WIDTH-1:0] rem;

  modport master (
    output start, op, num_a, num_b,
    input  busy, done, result, ovf, err, rem
  );

  modport slave (
    input  start, op, num_a, num_b,
    output busy, done, result, ovf, err, rem
  );
`else
  modport master (
    output start, op, num_a, num_b,
    input  busy, done, result, ovf, err
  );

  modport slave (
    input  start, op, num_a, num_b,
    output busy, done, result, ovf, err
  );
`endif

endinterface

// File: rtl/alu_iter_core.sv
// Iterative datapath: shift-add multiply (LSB first) and restoring divide
// (MSB first), one bit per step. hi/lo form a 2*WIDTH accumulator:
//   multiply: hi = running high product, lo = multiplier shifting out / low product
//   divide:   hi = partial remainder,   lo = dividend shifting out / quotient
// The *_nxt outputs are the values the accumulator takes on the next step.
module alu_iter_core #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             sel_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  logic [WIDTH-1:0] opnd_q;  // multiplicand or divisor
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH:0] mul_sum;
  logic [WIDTH:0] div_shift;
  logic [WIDTH:0] div_diff;

  // One iteration of whichever algorithm is selected.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (sel_div) begin
      // Negative trial difference means restore: keep the shifted remainder.
      if (div_diff[WIDTH]) begin
        hi_nxt = div_shift[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
      end else begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      // Carry of the partial sum shifts into the top of the product.
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Accumulator and operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      opnd_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else if (load) begin
      opnd_q <= sel_div ? b : a;
      hi_q   <= '0;
      lo_q   <= sel_div ? a : b;
    end else if (step) begin
      hi_q <= hi_nxt;
      lo_q <= lo_nxt;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Calculator ALU job sequencer: accepts one job at a time, resolves add/sub
// and the degenerate cases in one cycle, and runs multiply/divide through
// alu_iter_core for WIDTH steps. Optional remainder output: ALU_SEQ_REMAINDER_EN.
module alu_op_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input logic               clk,
  input logic               reset,
  alu_op_sequencer_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
`ifdef ALU_SEQ_REMAINDER_EN
  logic [WIDTH-1:0] rem_q, rem_d;
`endif

  logic             core_load;
  logic             core_step;
  logic             core_sel_div;
  logic [WIDTH-1:0] core_hi_nxt;
  logic [WIDTH-1:0] core_lo_nxt;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sub_diff;
  logic             accept;

  assign accept   = (state_q == SEQ_IDLE) && bus.start;
  assign add_sum  = {1'b0, bus.num_a} + {1'b0, bus.num_b};
  assign sub_diff = bus.num_a - bus.num_b;

  // At load time the opcode comes from the bus; afterwards from the latched copy.
  assign core_sel_div = accept ? (bus.op == OP_DIV) : (op_q == OP_DIV);

  alu_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (core_load),
    .step    (core_step),
    .sel_div (core_sel_div),
    .a       (bus.num_a),
    .b       (bus.num_b),
    .hi_nxt  (core_hi_nxt),
    .lo_nxt  (core_lo_nxt)
  );

  // Next-state, counter, result and flag updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
`ifdef ALU_SEQ_REMAINDER_EN
    rem_d     = rem_q;
`endif
    core_load = 1'b0;
    core_step = 1'b0;

    unique case (state_q)
      SEQ_IDLE: begin
        if (bus.start) begin
          op_d      = bus.op;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          err_d     = 1'b0;
          core_load = 1'b1;
          if (is_iter_op(bus.op, bus.num_b == '0)) begin
            // result is left untouched until the iterative job finishes
            state_d = SEQ_RUN;
          end else begin
            state_d = SEQ_DONE;
`ifdef ALU_SEQ_REMAINDER_EN
            rem_d   = '0;
`endif
            case (bus.op)
              OP_PLUS: begin
                result_d = add_sum[WIDTH-1:0];
                ovf_d    = add_sum[WIDTH];
              end
              OP_MINUS: begin
                result_d = sub_diff;
                ovf_d    = bus.num_a < bus.num_b;
              end
              OP_DIV: begin
                // only reached with a zero divisor
                result_d = '1;
                err_d    = 1'b1;
`ifdef ALU_SEQ_REMAINDER_EN
                rem_d    = bus.num_a;
`endif
              end
              default: begin
                result_d = '0;
                err_d    = 1'b1;
              end
            endcase
          end
        end
      end

      SEQ_RUN: begin
        core_step = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == LastCnt) begin
          state_d  = SEQ_DONE;
          cnt_d    = '0;
          result_d = core_lo_nxt;
          if (op_q == OP_DIV) begin
`ifdef ALU_SEQ_REMAINDER_EN
            rem_d = core_hi_nxt;
`endif
          end else begin
            ovf_d = |core_hi_nxt;
`ifdef ALU_SEQ_REMAINDER_EN
            rem_d = '0;
`endif
          end
        end
      end

      SEQ_DONE: begin
        state_d = SEQ_IDLE;
      end

      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  // State and held-result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEQ_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef ALU_SEQ_REMAINDER_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
`ifdef ALU_SEQ_REMAINDER_EN
      rem_q    <= rem_d;
`endif
    end
  end

  assign bus.busy   = (state_q != SEQ_IDLE);
  assign bus.done   = (state_q == SEQ_DONE);
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.err    = err_q;
`ifdef ALU_SEQ_REMAINDER_EN
  assign bus.rem    = rem_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: expected results come from an
// integer reference model and are queued when a job is driven.
module tb_alu_op_sequencer;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    logic        err;
    logic [15:0] rem;
    int          lat;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [15:0] last_res;
  exp_t sb[$];

  alu_op_sequencer_if #(.WIDTH(16)) bus ();

  alu_op_sequencer #(
    .WIDTH (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t m;
    logic [16:0] s;
    logic [31:0] p;
    m.res = 16'h0;
    m.ovf = 1'b0;
    m.err = 1'b0;
    m.rem = 16'h0;
    m.lat = 1;
    case (op)
      4'b0011: begin
        s = {1'b0, a} + {1'b0, b};
        m.res = s[15:0];
        m.ovf = s[16];
      end
      4'b1011: begin
        m.res = a - b;
        m.ovf = (a < b);
      end
      4'b0111: begin
        p = {16'h0, a} * {16'h0, b};
        m.res = p[15:0];
        m.ovf = (p[31:16] != 16'h0);
        m.lat = 17;
      end
      4'b1111: begin
        if (b == 16'h0) begin
          m.res = 16'hFFFF;
          m.err = 1'b1;
          m.rem = a;
        end else begin
          m.res = a / b;
          m.rem = a % b;
          m.lat = 17;
        end
      end
      default: m.err = 1'b1;
    endcase
    return m;
  endfunction

  // Drive one job; optionally pulse a conflicting start at latency cycle poke_at.
  task automatic do_job(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int poke_at);
    exp_t want;
    int   lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.num_a = a;
    bus.num_b = b;
    sb.push_back(model(op, a, b));
    @(posedge clk);
    #1;
    // scramble inputs after acceptance; the DUT must use latched values
    bus.start = 1'b0;
    bus.op    = 4'b0011;
    bus.num_a = ~a;
    bus.num_b = b + 16'd3;
    lat = 1;
    if (!bus.done) begin
      check_eq("run_busy", 32'(bus.busy), 32'd1);
      check_eq("run_ovf_cleared", 32'(bus.ovf), 32'd0);
      check_eq("run_err_cleared", 32'(bus.err), 32'd0);
      check_eq("run_result_held", 32'(bus.result), 32'(last_res));
    end
    while (!bus.done && lat < 40) begin
      if (lat == poke_at) begin
        bus.start = 1'b1;
        bus.op    = 4'b0011;
        bus.num_a = 16'h0001;
        bus.num_b = 16'h0001;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
    end
    want = sb.pop_front();
    check_eq("latency", 32'(lat), 32'(want.lat));
    check_eq("result", 32'(bus.result), 32'(want.res));
    check_eq("ovf", 32'(bus.ovf), 32'(want.ovf));
    check_eq("err", 32'(bus.err), 32'(want.err));
    check_eq("busy_in_done", 32'(bus.busy), 32'd1);
`ifdef ALU_SEQ_REMAINDER_EN
    check_eq("rem", 32'(bus.rem), 32'(want.rem));
`endif
    last_res = want.res;
    @(posedge clk);
    #1;
    check_eq("done_pulse_end", 32'(bus.done), 32'd0);
    check_eq("busy_after", 32'(bus.busy), 32'd0);
    check_eq("result_hold", 32'(bus.result), 32'(want.res));
  endtask

  initial begin
    int pulses;
    total     = 0;
    bad       = 0;
    last_res  = 16'h0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 4'b0011;
    bus.num_a = 16'h0;
    bus.num_b = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_result", 32'(bus.result), 32'd0);
    check_eq("rst_ovf", 32'(bus.ovf), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_job(4'b0011, 16'hFFF0, 16'h0020, 0);
    do_job(4'b1011, 16'd5, 16'd9, 0);
    do_job(4'b1011, 16'd9, 16'd5, 0);
    do_job(4'b0111, 16'd300, 16'd200, 0);
    do_job(4'b1011, 16'd0, 16'd1, 0);  // leaves ovf=1 so the next start must clear it
    do_job(4'b0111, 16'h0100, 16'h0100, 0);
    do_job(4'b1111, 16'd1000, 16'd7, 0);
    do_job(4'b1111, 16'd5, 16'd0, 0);
    do_job(4'b1111, 16'hFFFF, 16'hFFFF, 0);
    do_job(4'b1111, 16'd3, 16'd10, 0);
    do_job(4'b0111, 16'd300, 16'd200, 5);  // conflicting start during RUN
    do_job(4'b0101, 16'd12, 16'd34, 0);
    for (int i = 0; i < 4; i++) begin
      do_job(4'b0111, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 0);
      do_job(4'b1111, 16'($urandom_range(0, 65535)), 16'($urandom_range(1, 400)), 0);
    end

    // start held high: one single-cycle job per IDLE visit
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'b0011;
    bus.num_a = 16'd1;
    bus.num_b = 16'd1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    bus.start = 1'b0;
    check_eq("held_start_jobs", 32'(pulses), 32'd3);
    check_eq("held_start_result", 32'(bus.result), 32'd2);
    repeat (2) @(posedge clk);

    // reset in the middle of a multiply aborts it without a done pulse
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 4'b0111;
    bus.num_a = 16'd300;
    bus.num_b = 16'd200;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_done", 32'(bus.done), 32'd0);
    check_eq("abort_result", 32'(bus.result), 32'd0);
    check_eq("abort_ovf", 32'(bus.ovf), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    check_eq("abort_no_done", 32'(pulses), 32'd0);
    last_res = 16'h0;
    do_job(4'b0011, 16'd2, 16'd3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
